// File: rtl/sram_readback_if.sv
// Command, SRAM and FT240X signal bundle for the readback engine.
// master: the engine itself; slave: command decoder, SRAM and FIFO side.
interface sram_readback_if #(
    parameter int ADDR_W = 18,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [CNT_W-1:0]  word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_nOE;
    logic              sram_nUB;
    logic              sram_nLB;
    logic [15:0]       sram_data;
    logic [7:0]        ft_d_out;
    logic              ft_d_oe;
    logic              ft_nWR;
    logic              ft_TXE;

    modport master (
        input  start, abort, start_addr, word_count,
        input  sram_data, ft_TXE,
        output busy, done, sram_addr,
        output sram_nOE, sram_nUB, sram_nLB,
        output ft_d_out, ft_d_oe, ft_nWR
    );

    modport slave (
        output start, abort, start_addr, word_count,
        output sram_data, ft_TXE,
        input  busy, done, sram_addr,
        input  sram_nOE, sram_nUB, sram_nLB,
        input  ft_d_out, ft_d_oe, ft_nWR
    );
endinterface

// File: rtl/sram_readback.sv
// SRAM-to-FT240X readback engine, words sent high byte first.
// READBACK_CHECKSUM_EN appends a mod-256 byte sum after the block.
module sram_readback #(
    parameter int ADDR_W    = 18,
    parameter int CNT_W     = 8,
    parameter int SRAM_WAIT = 1,
    parameter int WR_PULSE  = 2
) (
    input  logic            clk24MHz,
    input  logic            reset,
    sram_readback_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, SRAM_RD,
        WAIT_H, WR_H, HOLD_H,
        WAIT_L, WR_L, HOLD_L,
        NEXT
`ifdef READBACK_CHECKSUM_EN
        , WAIT_C, WR_C, HOLD_C
`endif
    } state_t;

    localparam logic [1:0]      RD_LAST = 2'(SRAM_WAIT);
    localparam logic [1:0]      WR_LAST = 2'(WR_PULSE - 1);
    localparam logic [CNT_W:0]  CNT_ONE = (CNT_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W:0]    cnt;
    logic [15:0]       data;
    logic [1:0]        tmr;
    logic              last;
    logic              in_h, in_l, in_c;
    logic              wr, fin;
`ifdef READBACK_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign last = (cnt == CNT_ONE);

    always_ff @(posedge clk24MHz) begin
        if (reset) begin
            state <= IDLE;
            addr  <= '0;
            cnt   <= '0;
            data  <= '0;
            tmr   <= '0;
`ifdef READBACK_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            state <= state_nx;
            tmr   <= (state_nx == state) ? tmr + 2'd1 : 2'd0;
            if (state == IDLE && state_nx == SRAM_RD) begin
                addr <= bus.start_addr;
                // a zero count means a full 2^CNT_W block
                cnt  <= (bus.word_count == '0) ?
                        {1'b1, {CNT_W{1'b0}}} :
                        {1'b0, bus.word_count};
`ifdef READBACK_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (state == SRAM_RD && state_nx == WAIT_H)
                data <= bus.sram_data;
            if (state == NEXT) begin
                addr <= addr + ADDR_ONE;
                cnt  <= cnt - CNT_ONE;
            end
`ifdef READBACK_CHECKSUM_EN
            if (state == HOLD_H) csum <= csum + data[15:8];
            if (state == HOLD_L) csum <= csum + data[7:0];
`endif
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start && !bus.abort) state_nx = SRAM_RD;
            SRAM_RD: if (tmr == RD_LAST) state_nx = WAIT_H;
            WAIT_H:  if (!bus.ft_TXE) state_nx = WR_H;
            WR_H:    if (tmr == WR_LAST) state_nx = HOLD_H;
            HOLD_H:  state_nx = WAIT_L;
            WAIT_L:  if (!bus.ft_TXE) state_nx = WR_L;
            WR_L:    if (tmr == WR_LAST) state_nx = HOLD_L;
            HOLD_L:  state_nx = NEXT;
`ifdef READBACK_CHECKSUM_EN
            NEXT:    state_nx = last ? WAIT_C : SRAM_RD;
            WAIT_C:  if (!bus.ft_TXE) state_nx = WR_C;
            WR_C:    if (tmr == WR_LAST) state_nx = HOLD_C;
            HOLD_C:  state_nx = IDLE;
`else
            NEXT:    state_nx = last ? IDLE : SRAM_RD;
`endif
            default: state_nx = IDLE;
        endcase
        if (state != IDLE && bus.abort) state_nx = IDLE;
    end

    assign in_h = (state inside {WAIT_H, WR_H, HOLD_H});
    assign in_l = (state inside {WAIT_L, WR_L, HOLD_L});
`ifdef READBACK_CHECKSUM_EN
    assign in_c = (state inside {WAIT_C, WR_C, HOLD_C});
    assign wr   = (state inside {WR_H, WR_L, WR_C});
    assign fin  = (state == HOLD_C);
`else
    assign in_c = 1'b0;
    assign wr   = (state inside {WR_H, WR_L});
    assign fin  = (state == NEXT) && last;
`endif

    assign bus.done     = fin && !bus.abort;
    assign bus.busy     = (state != IDLE) && !bus.done;
    assign bus.sram_addr = addr;
    assign bus.sram_nOE = (state != SRAM_RD);
    assign bus.sram_nUB = (state != SRAM_RD);
    assign bus.sram_nLB = (state != SRAM_RD);
    assign bus.ft_d_oe  = in_h | in_l | in_c;
    assign bus.ft_nWR   = !wr;

    always_comb begin
        bus.ft_d_out = 8'h00;
        unique case (1'b1)
            in_h:    bus.ft_d_out = data[15:8];
            in_l:    bus.ft_d_out = data[7:0];
`ifdef READBACK_CHECKSUM_EN
            in_c:    bus.ft_d_out = csum;
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/sram_readback.md
# sram_readback

Readback engine for the ROM emulator CPLD, the reverse of the FT240X-to-SRAM load path. On a start pulse from the command decoder it reads a block of 16-bit words from the emulation SRAM, starting at a given address, and streams each word to the host over the FT240X FIFO, high byte first. The host uses it to verify a load. It runs only while the design is in LOAD mode, where the CPLD owns the address and data buses.

## Interface
Parameters:
- ADDR_W, 18, SRAM word-address width.
- CNT_W, 8, width of the word-count input.
- SRAM_WAIT, 1, extra cycles `sram_nOE` is held low before data is sampled (0–3).
- WR_PULSE, 2, cycles `ft_nWR` is held low per byte (1–3).

Ports:
- clk24MHz  in  1  24 MHz system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a readback; ignored while `busy`.
- abort  in  1  level; cancels the transfer in progress.
- start_addr  in  ADDR_W  first word address, captured on `start`.
- word_count  in  CNT_W  number of words to send, captured on `start`; 0 means 2^CNT_W.
- busy  out  1  high from the cycle after `start` until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- sram_addr  out  ADDR_W  current SRAM word address.
- sram_nOE, sram_nUB, sram_nLB  out  1 each  SRAM read strobes, active low.
- sram_data  in  16  SRAM data bus.
- ft_d_out  out  8  byte to the FT240X.
- ft_d_oe  out  1  top level drives `ft240x_d` from `ft_d_out` when high.
- ft_nWR  out  1  FT240X write strobe, active low.
- ft_TXE  in  1  FT240X transmit FIFO full; high means do not write.

## Operation
- States: IDLE, SRAM_RD, WAIT_H, WR_H, HOLD_H, WAIT_L, WR_L, HOLD_L, NEXT, plus CSUM states when enabled (see Configuration).
- **IDLE:** on `start`, capture `start_addr` into the address register and `word_count` into the remaining-word counter (0 loads 2^CNT_W), then go to SRAM_RD.
- **SRAM_RD:** lasts SRAM_WAIT+1 cycles with `sram_nOE`, `sram_nUB` and `sram_nLB` all low. `sram_data` is latched on the final edge, then go to WAIT_H.
- **WAIT_x:** `ft_d_oe` is high and `ft_d_out` carries the byte (bits 15:8 for H, bits 7:0 for L). Stays here while `ft_TXE` is 1; moves to WR_x on the first edge that samples `ft_TXE` = 0.
- **WR_x:** `ft_nWR` is low for WR_PULSE cycles, with data held.
- **HOLD_x:** `ft_nWR` is high and data is still driven for 1 cycle. HOLD_H goes to WAIT_L; HOLD_L goes to NEXT.
- **NEXT:** increment the address modulo 2^ADDR_W (0x3FFFF wraps to 0x00000) and decrement the remaining-word counter. If the counter reaches 0, pulse `done` and go to IDLE; otherwise go to SRAM_RD.
- **Outside WAIT/WR/HOLD:** `ft_d_oe` is 0. The SRAM strobes are high outside SRAM_RD.
- **Abort:** `abort` sampled high in any non-IDLE state sends the block to IDLE on that edge. It does not pulse `done`. `ft_nWR` and the SRAM strobes return high and `ft_d_oe` returns low in the next cycle.
- **Reset:** reset mid-transfer behaves like abort and also clears all registers.
- **Abort and start together:** if `abort` and `start` are high in the same IDLE cycle, the start is ignored.

## Timing
- **Reset values:**
  - `busy`, `done` and `ft_d_oe` = 0.
  - `ft_nWR`, `sram_nOE`, `sram_nUB` and `sram_nLB` = 1.
  - `sram_addr` and `ft_d_out` = 0.
- **Start latency:** `start` is sampled at edge 0; SRAM_RD and `busy` begin in cycle 1.
- **Write setup:** data is valid at least 1 cycle before `ft_nWR` falls and for 1 cycle after it rises.
- **TXE rule:** `ft_TXE` is sampled only in WAIT states. A TXE rise during WR_x does not shorten the pulse.
- **Per-word cost with `ft_TXE` held low:** (SRAM_WAIT+1) + 2×(WR_PULSE+2) + 1 cycles, which is 11 with the defaults.
- **Completion:** `done` is high for exactly 1 cycle (the NEXT→IDLE transition), and `busy` drops in the same cycle.

## Configuration
- **READBACK_CHECKSUM_EN defined:**
  - An 8-bit running sum (mod 256) of every transmitted data byte is kept; it is cleared on `start`.
  - After the last NEXT, the block passes through WAIT_C, WR_C and HOLD_C, sending the sum as one extra byte with the same handshake.
  - `done` pulses after HOLD_C.
  - Abort in the CSUM states behaves as in Operation.
- **Undefined:** no CSUM states exist, and `done` follows the last NEXT.

## Test plan
- **Basic transfer:** SRAM[0x00010]=0xA55A, SRAM[0x00011]=0x1234, TXE=0, start_addr=0x00010, word_count=2 → bytes A5, 5A, 12, 34 in order; `done` at cycle 22 after `start`; 4 `ft_nWR` pulses of 2 cycles each.
- **Backpressure:** TXE=1 for 10 cycles while in WAIT_L → `ft_nWR` stays high and data stays 0x5A; the write starts the cycle after TXE falls; no byte is lost or duplicated.
- **Wrap:** start_addr=0x3FFFF, word_count=2 → `sram_addr` reads 0x3FFFF then 0x00000.
- **Count 0:** word_count=0 → exactly 256 words (512 bytes) sent, then one `done`.
- **Abort and restart:** abort asserted during WR_H of word 1 → next cycle `ft_nWR`=1 and `ft_d_oe`=0, no `done`; a following `start` runs cleanly. A `start` pulse while `busy` is ignored.
- **Checksum (READBACK_CHECKSUM_EN):** data bytes A5 5A 12 34 → fifth byte 0x45, then `done`.
